// File: rtl/wam_pkg.sv
// wam_pkg: shared whack-a-mole types and constants
package wam_pkg;
  typedef enum logic [2:0] {IDLE, WAIT, ARMED, RESOLVED, DONE} state_t;
  localparam int NUM_LIGHTS_DEF = 9;
  localparam int CNT_W_DEF = 6;
  localparam int NORMAL_MAX_HITS = 25;
  localparam int EXTENDED_MAX_HITS = 50;
endpackage

// File: rtl/sat_counter.sv
// sat_counter: saturating up-counter with synchronous clear and async active-low reset
module sat_counter #(
  parameter int W = 6
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] q
);
  // clear wins over increment; hold at all-ones instead of wrapping
  always_ff @(posedge clk or negedge reset)
    if (!reset) q <= '0;
    else if (clr) q <= '0;
    else if (inc && q != '1) q <= q + 1'b1;
endmodule

// File: rtl/hit_scorer.sv
// hit_scorer: resolves mole flicks into hits/misses and tracks game over; HIT_SCORER_STREAK_EN adds best_streak
module hit_scorer
  import wam_pkg::*;
#(
  parameter int NUM_LIGHTS = NUM_LIGHTS_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [NUM_LIGHTS-1:0] lights,
  input  logic                  key_valid,
  input  logic [3:0]            key_code,
  input  logic [CNT_W-1:0]      max_hits,
  input  logic                  sudden_death,
  output logic [CNT_W-1:0]      total_points,
  output logic [CNT_W-1:0]      misses,
  output logic [CNT_W-1:0]      flicks,
  output logic                  hit_pulse,
  output logic                  miss_pulse,
  output logic                  game_over,
  output logic [CNT_W-1:0]      best_streak
);
  state_t st, nxt;
  logic [NUM_LIGHTS-1:0] lights_q;
  logic [CNT_W-1:0] budget;
  logic [15:0] lights_ext;
  logic rise, fall, hit, hit_evt, miss_evt, flick_evt;
  state_t after_flick;
  // zero padding makes codes >= NUM_LIGHTS read as unlit, i.e. a wrong key
  assign lights_ext = 16'(lights);
  assign hit = key_valid && lights_ext[key_code];
  assign rise = (lights != '0) && (lights_q == '0);
  assign fall = (lights == '0) && (lights_q != '0);
  assign after_flick = (flicks == budget) ? DONE : WAIT;
  assign game_over = (st == DONE);
  // state, edge-detect history, budget latch and registered pulses
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      st <= IDLE;
      lights_q <= '0;
      budget <= '0;
      hit_pulse <= 1'b0;
      miss_pulse <= 1'b0;
    end else begin
      st <= nxt;
      lights_q <= lights;
      budget <= (st == IDLE) ? max_hits : budget;
      hit_pulse <= hit_evt;
      miss_pulse <= miss_evt;
    end
  // next state and scoring events; nothing happens while start is low
  always_comb begin
    nxt = st;
    hit_evt = 1'b0;
    miss_evt = 1'b0;
    flick_evt = 1'b0;
    case (st)
      IDLE: if (start) nxt = (max_hits == '0) ? DONE : WAIT;
      WAIT: if (start && rise) begin
        flick_evt = 1'b1;
        nxt = ARMED;
      end
      ARMED: if (start) begin
        if (hit) begin
          hit_evt = 1'b1;
          nxt = RESOLVED;
        end else if (key_valid || fall) begin
          miss_evt = 1'b1;
          nxt = sudden_death ? DONE : fall ? after_flick : RESOLVED;
        end
      end
      RESOLVED: if (start && fall) nxt = after_flick;
      default: nxt = st;
    endcase
  end
  sat_counter #(.W(CNT_W)) u_points (.clk(clk), .reset(reset), .inc(hit_evt), .clr(1'b0), .q(total_points));
  sat_counter #(.W(CNT_W)) u_misses (.clk(clk), .reset(reset), .inc(miss_evt), .clr(1'b0), .q(misses));
  sat_counter #(.W(CNT_W)) u_flicks (.clk(clk), .reset(reset), .inc(flick_evt), .clr(1'b0), .q(flicks));
`ifdef HIT_SCORER_STREAK_EN
  logic [CNT_W-1:0] cur_streak;
  sat_counter #(.W(CNT_W)) u_streak (.clk(clk), .reset(reset), .inc(hit_evt), .clr(miss_evt), .q(cur_streak));
  // best run seen so far, trailing the live streak by one cycle
  always_ff @(posedge clk or negedge reset)
    if (!reset) best_streak <= '0;
    else best_streak <= (cur_streak > best_streak) ? cur_streak : best_streak;
`else
  assign best_streak = '0;
`endif
endmodule

// File: tb/tb_hit_scorer.sv
// tb_hit_scorer: directed scoreboard bench for hit_scorer
module tb_hit_scorer;
  import wam_pkg::*;
  logic clk = 1'b0;
  logic reset, start, key_valid, sudden_death;
  logic [8:0] lights;
  logic [3:0] key_code;
  logic [5:0] max_hits, total_points, misses, flicks, best_streak;
  logic hit_pulse, miss_pulse, game_over;
  typedef struct {bit hit; int pts; int mis;} exp_t;
  exp_t sbq[$];
  int vectors = 0, miscompares = 0, hp_cnt = 0;
  int exp_pts = 0, exp_mis = 0, exp_flk = 0;

  hit_scorer dut (
    .clk(clk), .reset(reset), .start(start), .lights(lights), .key_valid(key_valid),
    .key_code(key_code), .max_hits(max_hits), .sudden_death(sudden_death),
    .total_points(total_points), .misses(misses), .flicks(flicks), .hit_pulse(hit_pulse),
    .miss_pulse(miss_pulse), .game_over(game_over), .best_streak(best_streak)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input int act, input int req);
    vectors++;
    if (act != req) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", n, act, req, $time);
    end
  endtask

  // monitor: every pulse must match the next scoreboard entry
  always @(negedge clk)
    if (hit_pulse || miss_pulse) begin
      if (hit_pulse) hp_cnt++;
      chk("dual_pulse", int'(hit_pulse && miss_pulse), 0);
      if (sbq.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_pulse: got hit=%0b miss=%0b expected none at %0t", hit_pulse, miss_pulse, $time);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk("pulse_kind", int'(hit_pulse), int'(e.hit));
        chk("pulse_points", int'(total_points), e.pts);
        chk("pulse_misses", int'(misses), e.mis);
      end
    end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic up(input int i, input bit live);
    lights = 9'(1 << i);
    if (live) exp_flk++;
    step();
    step();
  endtask

  // kind: 0 ignored, 1 hit, 2 miss
  task automatic press(input int code, input int kind);
    key_valid = 1'b1;
    key_code = 4'(code);
    if (kind == 1) begin exp_pts++; sbq.push_back('{1'b1, exp_pts, exp_mis}); end
    if (kind == 2) begin exp_mis++; sbq.push_back('{1'b0, exp_pts, exp_mis}); end
    step();
    key_valid = 1'b0;
    step();
  endtask

  task automatic drop(input bit miss);
    lights = '0;
    if (miss) begin exp_mis++; sbq.push_back('{1'b0, exp_pts, exp_mis}); end
    step();
  endtask

  task automatic drain();
    for (int i = 0; i < 8 && sbq.size() > 0; i++) step();
    chk("sb_drain", sbq.size(), 0);
  endtask

  task automatic chk_zero(input string n);
    chk({n, "_points"}, int'(total_points), 0);
    chk({n, "_misses"}, int'(misses), 0);
    chk({n, "_flicks"}, int'(flicks), 0);
    chk({n, "_hitp"}, int'(hit_pulse), 0);
    chk({n, "_missp"}, int'(miss_pulse), 0);
    chk({n, "_over"}, int'(game_over), 0);
    chk({n, "_streak"}, int'(best_streak), 0);
  endtask

  task automatic new_game(input int mh, input bit sd);
    reset = 1'b0;
    start = 1'b1;
    max_hits = 6'(mh);
    sudden_death = sd;
    lights = '0;
    key_valid = 1'b0;
    step();
    reset = 1'b1;
    exp_pts = 0; exp_mis = 0; exp_flk = 0; hp_cnt = 0;
    step();
  endtask

  task automatic chk_cnt(input string n, input int p, input int m, input int f);
    chk({n, "_points"}, int'(total_points), p);
    chk({n, "_misses"}, int'(misses), m);
    chk({n, "_flicks"}, int'(flicks), f);
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; lights = '0; key_valid = 1'b0; key_code = '0;
    max_hits = 6'(NORMAL_MAX_HITS); sudden_death = 1'b0;
    #12;
    chk_zero("reset");
    step();
    reset = 1'b1;
    start = 1'b1;
    step();
    // full 25-flick game, all hits
    for (int i = 0; i < NORMAL_MAX_HITS; i++) begin
      up(i % 9, 1'b1);
      press(i % 9, 1);
      if (i == NORMAL_MAX_HITS - 1) chk("over_before_last_fall", int'(game_over), 0);
      drop(1'b0);
    end
    chk("over_after_last_fall", int'(game_over), 1);
    drain();
    chk_cnt("full", 25, 0, 25);
    chk("full_hit_pulses", hp_cnt, 25);
    up(2, 1'b0); press(2, 0); drop(1'b0);
    chk_cnt("done_frozen", 25, 0, 25);
    // unanswered flick
    new_game(25, 0);
    up(4, 1'b1); drop(1'b1); drain();
    chk_cnt("nopress", 0, 1, 1);
    // wrong key then right key in one flick
    new_game(25, 0);
    up(4, 1'b1); press(2, 2); press(4, 0); drop(1'b0); drain();
    chk_cnt("wrong_then_right", 0, 1, 1);
    // key coincident with fall, invalid code, key in WAIT
    new_game(25, 0);
    up(3, 1'b1);
    lights = '0; key_valid = 1'b1; key_code = 4'd3;
    exp_mis++; sbq.push_back('{1'b0, exp_pts, exp_mis});
    step();
    key_valid = 1'b0;
    step();
    chk("coincident_not_over", int'(game_over), 0);
    up(5, 1'b1); press(12, 2); drop(1'b0); press(5, 0); drain();
    chk_cnt("coincident_invalid_wait", 0, 2, 2);
    chk("coincident_over", int'(game_over), 0);
    // sudden death
    new_game(25, 1);
    up(0, 1'b1); press(0, 1); drop(1'b0);
    up(1, 1'b1); press(1, 1); drop(1'b0);
    up(2, 1'b1);
    key_valid = 1'b1; key_code = 4'd7;
    exp_mis++; sbq.push_back('{1'b0, exp_pts, exp_mis});
    step();
    key_valid = 1'b0;
    chk("sd_over_before_fall", int'(game_over), 1);
    drop(1'b0); up(3, 1'b0); press(3, 0); drop(1'b0); drain();
    chk_cnt("sd_frozen", 2, 1, 3);
    // reset mid-flick
    new_game(25, 0);
    up(6, 1'b1);
    reset = 1'b0;
    #1;
    chk_zero("mid_reset");
    lights = '0;
    step();
    reset = 1'b1;
    exp_pts = 0; exp_mis = 0; exp_flk = 0;
    step();
    up(1, 1'b1); press(1, 1); drop(1'b0);
    up(8, 1'b1); press(8, 1); drop(1'b0); drain();
    chk_cnt("after_reset", 2, 0, 2);
    // streak: hit hit miss hit
    new_game(25, 0);
    up(0, 1'b1); press(0, 1); drop(1'b0);
    up(1, 1'b1); press(1, 1); drop(1'b0);
    up(2, 1'b1); press(3, 2); drop(1'b0);
    up(4, 1'b1); press(4, 1); drop(1'b0); drain();
    chk_cnt("streak", 3, 1, 4);
`ifdef HIT_SCORER_STREAK_EN
    chk("best_streak", int'(best_streak), 2);
`else
    chk("best_streak", int'(best_streak), 0);
`endif
    // zero budget goes straight to game over
    new_game(0, 0);
    chk("zero_budget_over", int'(game_over), 1);
    up(0, 1'b0); press(0, 0); drop(1'b0);
    chk_cnt("zero_budget", 0, 0, 0);
    // start low freezes scoring
    new_game(25, 0);
    start = 1'b0;
    up(2, 1'b0); press(2, 0);
    start = 1'b1;
    step();
    drop(1'b0);
    chk_cnt("start_low", 0, 0, 0);
    chk("start_low_over", int'(game_over), 0);
    up(2, 1'b1); press(2, 1); drop(1'b0); drain();
    chk_cnt("start_resume", 1, 0, 1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
